// File: rtl/pwm_dac_gen.sv
// Dithered PWM generator for one slow DAC channel: 8-bit base duty plus a
// 16-period dither pattern, reloaded atomically at each super-cycle boundary.
module pwm_dac_gen #(
  parameter int unsigned FULL = 156,
  parameter int unsigned CW   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        sync_o,
  output logic        cfg_ld_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(FULL - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    bcnt;
  logic [7:0]    duty_r;
  logic [15:0]   dith_r;

  logic          cnt_wrap_c;
  logic          boundary_c;
  logic [8:0]    thr_c;

  assign cnt_wrap_c = (cnt == CNT_LAST);
  assign boundary_c = cnt_wrap_c && (bcnt == 4'd15);
  // Nine bits so duty 255 plus a dither clock cannot wrap.
  assign thr_c      = 9'(duty_r) + 9'(dith_r[bcnt]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= CNT_LAST;
      bcnt     <= 4'd15;
      duty_r   <= '0;
      dith_r   <= '0;
      pwm_o    <= 1'b0;
      sync_o   <= 1'b0;
      cfg_ld_o <= 1'b0;
    end else begin
      cnt <= cnt_wrap_c ? '0 : cnt + CW'(1);
      if (cnt_wrap_c) bcnt <= bcnt + 4'd1;
      // Setpoint is only taken at the super-cycle boundary.
      if (boundary_c) begin
        duty_r <= cfg_i[23:16];
        dith_r <= cfg_i[15:0];
      end
      cfg_ld_o <= boundary_c;
      pwm_o    <= (9'(cnt) < thr_c);
      sync_o   <= (cnt == '0) && (bcnt == 4'd0);
    end
  end

endmodule

// File: tb/tb_pwm_dac_gen.sv
// Randomised self-checking bench for pwm_dac_gen against a cycle-position
// model (FULL=156 instance "a", FULL=4 instance "b").
module tb_pwm_dac_gen;

  localparam int FA = 156;
  localparam int LA = 16 * FA;
  localparam int FB = 4;
  localparam int LB = 16 * FB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cfg_a = '0;
  logic [23:0] cfg_b = '0;
  logic        pwm_a, sync_a, ld_a;
  logic        pwm_b, sync_b, ld_b;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, setpoint in force, setpoint pending.
  int          k_a = 0, k_b = 0;
  logic [23:0] cur_a = '0, pend_a = '0, cur_b = '0, pend_b = '0;
  logic [2:0]  e_a, e_b;

  pwm_dac_gen #(.FULL(FA), .CW(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg_a),
    .pwm_o(pwm_a), .sync_o(sync_a), .cfg_ld_o(ld_a)
  );

  pwm_dac_gen #(.FULL(FB), .CW(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg_b),
    .pwm_o(pwm_b), .sync_o(sync_b), .cfg_ld_o(ld_b)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Expected {pwm, sync, cfg_ld} after edge k (k=1 is first edge after release).
  function automatic logic [2:0] expect_bits(input int f, input int k, input logic [23:0] c);
    int l, pos, per, hi;
    logic ld;
    l  = 16 * f;
    ld = ((k - 1) % l == 0);
    if (k < 2) return {2'b00, ld};
    pos = (k - 2) % l;
    per = pos / f;
    hi  = int'(c[23:16]) + int'(c[per]);
    if (hi > f) hi = f;
    return {((pos % f) < hi), (pos == 0), ld};
  endfunction

  // Advance one clock, update both models, settle to sample point.
  task automatic tick();
    @(posedge clk);
    k_a++;
    if ((k_a - 1) % LA == 0) pend_a = cfg_a;
    if (k_a >= 2 && (k_a - 2) % LA == 0) cur_a = pend_a;
    k_b++;
    if ((k_b - 1) % LB == 0) pend_b = cfg_b;
    if (k_b >= 2 && (k_b - 2) % LB == 0) cur_b = pend_b;
    #1;
    e_a = expect_bits(FA, k_a, cur_a);
    e_b = expect_bits(FB, k_b, cur_b);
  endtask

  task automatic restart_model();
    k_a = 0; k_b = 0;
    cur_a = '0; pend_a = '0; cur_b = '0; pend_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_a = 24'h0F0000;
    cfg_b = 24'h010003;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pwm_a, sync_a, ld_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_a: got %b required 000", {pwm_a, sync_a, ld_a});
    end
    checks++;
    if ({pwm_b, sync_b, ld_b} !== 3'b000) begin
      errors++;
      $display("FAIL reset_b: got %b required 000", {pwm_b, sync_b, ld_b});
    end
    rst = 1'b0;
    restart_model();
  endtask

  task automatic test_basic_duty();
    int last_sync = 0;
    for (int i = 0; i < 2 * LA + 2; i++) begin
      tick();
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL basic k=%0d: got %b required %b", k_a, {pwm_a, sync_a, ld_a}, e_a);
      end
      if (sync_a) begin
        if (last_sync > 0) begin
          checks++;
          if (k_a - last_sync !== LA) begin
            errors++;
            $display("FAIL sync_interval: got %0d required %0d", k_a - last_sync, LA);
          end
        end
        last_sync = k_a;
      end
    end
  endtask

  task automatic test_dither();
    bit found = 0;
    int total = 0;
    cfg_a = 24'h4E5555;
    for (int i = 0; i < 2 * LA + 4 && !found; i++) begin
      tick();
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL dither_wait k=%0d: got %b required %b", k_a, {pwm_a, sync_a, ld_a}, e_a);
      end
      if ((k_a - 2) % LA == 0 && cur_a == 24'h4E5555) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL dither_load: got no boundary required one within %0d clocks", 2 * LA + 4);
    end
    total = int'(pwm_a);
    for (int i = 1; i < LA; i++) begin
      tick();
      total += int'(pwm_a);
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL dither k=%0d: got %b required %b", k_a, {pwm_a, sync_a, ld_a}, e_a);
      end
    end
    checks++;
    if (total !== 1256) begin
      errors++;
      $display("FAIL dither_total: got %0d required 1256", total);
    end
  endtask

  task automatic test_saturation();
    logic [23:0] pats [3];
    pats[0] = 24'hFF0000; pats[1] = 24'h9BFFFF; pats[2] = 24'h000000;
    for (int p = 0; p < 3; p++) begin
      cfg_a = pats[p];
      for (int i = 0; i < 2 * LA; i++) begin
        tick();
        checks++;
        if ({pwm_a, sync_a, ld_a} !== e_a) begin
          errors++;
          $display("FAIL saturation cfg=%h k=%0d: got %b required %b",
                   pats[p], k_a, {pwm_a, sync_a, ld_a}, e_a);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    bit found = 0;
    int lds = 0;
    int hi = 0;
    cfg_a = 24'h0F0000;
    for (int i = 0; i < 2 * LA + 4 && !found; i++) begin
      tick();
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL midchg_pre k=%0d: got %b required %b", k_a, {pwm_a, sync_a, ld_a}, e_a);
      end
      if ((k_a - 2) % LA == 7 * FA + 20 && cur_a == 24'h0F0000) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midchg_reach: got no bcnt=7 point required one");
    end
    cfg_a = 24'h750000;
    found = 0;
    for (int i = 0; i < LA && !found; i++) begin
      tick();
      lds += int'(ld_a);
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL midchg k=%0d: got %b required %b", k_a, {pwm_a, sync_a, ld_a}, e_a);
      end
      if (sync_a) found = 1;
    end
    checks++;
    if (lds !== 1) begin
      errors++;
      $display("FAIL midchg_ld_count: got %0d required 1", lds);
    end
    hi = int'(pwm_a);
    for (int i = 1; i < FA; i++) begin
      tick();
      hi += int'(pwm_a);
    end
    checks++;
    if (hi !== 117) begin
      errors++;
      $display("FAIL midchg_first_period: got %0d high required 117", hi);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 2 * FA && !found; i++) begin
      tick();
      if (pwm_a) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL arst_setup: got pwm low throughout required a high cycle");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pwm_a, sync_a, ld_a} !== 3'b000) begin
      errors++;
      $display("FAIL arst_async: got %b required 000 before next edge", {pwm_a, sync_a, ld_a});
    end
    cfg_a = 24'h9C0000;
    @(posedge clk);
    #1;
    checks++;
    if ({pwm_a, sync_a, ld_a} !== 3'b000) begin
      errors++;
      $display("FAIL arst_hold: got %b required 000", {pwm_a, sync_a, ld_a});
    end
    rst = 1'b0;
    restart_model();
    for (int i = 0; i < 2 * LA; i++) begin
      tick();
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL arst_reload k=%0d: got %b required %b", k_a, {pwm_a, sync_a, ld_a}, e_a);
      end
    end
  endtask

  task automatic test_small_period();
    int last_sync = 0;
    int total = 0;
    int sc = 0;
    for (int i = 0; i < 3 * LB; i++) begin
      tick();
      checks++;
      if ({pwm_b, sync_b, ld_b} !== e_b) begin
        errors++;
        $display("FAIL small k=%0d: got %b required %b", k_b, {pwm_b, sync_b, ld_b}, e_b);
      end
      if (sync_b) begin
        if (last_sync > 0) begin
          checks++;
          if (k_b - last_sync !== LB) begin
            errors++;
            $display("FAIL small_sync_interval: got %0d required %0d", k_b - last_sync, LB);
          end
          if (sc == 1) begin
            checks++;
            if (total !== 18) begin
              errors++;
              $display("FAIL small_total: got %0d required 18", total);
            end
          end
        end
        sc++;
        total = 0;
        last_sync = k_b;
      end
      total += int'(pwm_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3 * LA; i++) begin
      tick();
      checks++;
      if ({pwm_a, sync_a, ld_a} !== e_a) begin
        errors++;
        $display("FAIL rand_a k=%0d cfg=%h: got %b required %b",
                 k_a, cur_a, {pwm_a, sync_a, ld_a}, e_a);
      end
      checks++;
      if ({pwm_b, sync_b, ld_b} !== e_b) begin
        errors++;
        $display("FAIL rand_b k=%0d cfg=%h: got %b required %b",
                 k_b, cur_b, {pwm_b, sync_b, ld_b}, e_b);
      end
      if ($urandom_range(0, 499) == 0) cfg_a = 24'($urandom);
      if ($urandom_range(0, 19) == 0)  cfg_b = 24'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_dither();
    test_saturation();
    test_mid_change();
    test_async_reset();
    test_small_period();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
